// File: rtl/bridge_key_pkg.sv
// Shared types and key-pattern classification for the H-bridge key monitor.
package bridge_key_pkg;

  localparam logic [3:0] KEYS_FWD = 4'b1001;
  localparam logic [3:0] KEYS_REV = 4'b0110;

  typedef enum logic [1:0] {StIdle, StMeasure, StFault} state_e;

  typedef enum logic [1:0] {KeyOff, KeyFwd, KeyRev, KeyShoot} key_class_e;

  // Shoot-through on either leg dominates any other interpretation of the pattern.
  function automatic key_class_e classify_keys(input logic [3:0] keys);
    key_class_e cls;
    cls = KeyOff;
    if ((keys[3] & keys[2]) | (keys[1] & keys[0])) begin
      cls = KeyShoot;
    end else if (keys == KEYS_FWD) begin
      cls = KeyFwd;
    end else if (keys == KEYS_REV) begin
      cls = KeyRev;
    end
    return cls;
  endfunction

endpackage

// File: rtl/pwm_period_counter.sv
// Period/high-time counters with saturation and capture registers for duty and period.
module pwm_period_counter #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic             capture_i,
  input  logic             timeout_i,
  input  logic             count_i,
  input  logic             drive_i,
  output logic             at_limit_o,
  output logic [CNT_W-1:0] duty_o,
  output logic [CNT_W-1:0] period_o
);

  localparam logic [CNT_W-1:0] Limit = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] One   = CNT_W'(1);

  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] hi_q, hi_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] duty_q, duty_d;

  always_comb begin
    per_d    = per_q;
    hi_d     = hi_q;
    period_d = period_q;
    duty_d   = duty_q;
    if (clear_i) begin
      per_d = '0;
      hi_d  = '0;
    end else if (load_i) begin
      if (capture_i) begin
        period_d = per_q;
        duty_d   = hi_q;
      end
      // The rising cycle itself is the first cycle of the new period.
      per_d = One;
      hi_d  = One;
    end else if (timeout_i) begin
      period_d = Limit;
      duty_d   = drive_i ? Limit : '0;
      per_d    = '0;
      hi_d     = '0;
    end else if (count_i) begin
      per_d = (per_q >= Limit) ? Limit : per_q + One;
      if (drive_i) begin
        hi_d = (hi_q >= Limit) ? Limit : hi_q + One;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      per_q    <= '0;
      hi_q     <= '0;
      period_q <= '0;
      duty_q   <= '0;
    end else begin
      per_q    <= per_d;
      hi_q     <= hi_d;
      period_q <= period_d;
      duty_q   <= duty_d;
    end
  end

  assign at_limit_o = (per_q == Limit);
  assign duty_o     = duty_q;
  assign period_o   = period_q;

endmodule

// File: rtl/bridge_key_monitor.sv
// Recovers PWM, direction, duty and period from H-bridge key gates; latches shoot-through.
module bridge_key_monitor
  import bridge_key_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic [3:0]       signals,
  input  logic             fault_clear,
  output logic             pwm_out,
  output logic             direction_out,
  output logic [CNT_W-1:0] duty,
  output logic [CNT_W-1:0] period,
  output logic             meas_valid,
  output logic             stalled,
  output logic             fault
);

  logic [3:0] s_q;
  logic       drv_prev_q;
  state_e     state_q, state_d;
  logic       pwm_q, pwm_d;
  logic       dir_q, dir_d;
  logic       fault_q, fault_d;
  logic       meas_valid_q, meas_valid_d;
  logic       stalled_q, stalled_d;

  key_class_e key_cls;
  logic       shoot, drive, rise, at_limit;
  logic       cnt_clear, cnt_load, cnt_capture, cnt_timeout, cnt_count;

  assign key_cls = classify_keys(s_q);
  assign shoot   = (key_cls == KeyShoot);
  assign drive   = (key_cls == KeyFwd) || (key_cls == KeyRev);
  // FWD->REV without an OFF cycle keeps drive high, so it is not a new edge.
  assign rise    = drive & ~drv_prev_q;

  always_comb begin
    state_d      = state_q;
    meas_valid_d = 1'b0;
    stalled_d    = stalled_q;
    cnt_clear    = 1'b0;
    cnt_load     = 1'b0;
    cnt_capture  = 1'b0;
    cnt_timeout  = 1'b0;
    cnt_count    = 1'b0;
    if (shoot) begin
      state_d   = StFault;
      cnt_clear = 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          if (rise) begin
            state_d  = StMeasure;
            cnt_load = 1'b1;
          end
        end
        StMeasure: begin
          if (rise) begin
            cnt_load     = 1'b1;
            cnt_capture  = 1'b1;
            meas_valid_d = 1'b1;
            stalled_d    = 1'b0;
          end else if (at_limit) begin
            cnt_timeout  = 1'b1;
            meas_valid_d = 1'b1;
            stalled_d    = 1'b1;
            state_d      = StIdle;
          end else begin
            cnt_count = 1'b1;
          end
        end
        StFault: begin
          cnt_clear = 1'b1;
          if (fault_clear) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    dir_d = dir_q;
    if (key_cls == KeyFwd) begin
      dir_d = 1'b0;
    end else if (key_cls == KeyRev) begin
      dir_d = 1'b1;
    end
    pwm_d   = drive & (state_d != StFault);
    fault_d = (state_d == StFault);
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      s_q          <= 4'b0000;
      drv_prev_q   <= 1'b0;
      state_q      <= StIdle;
      pwm_q        <= 1'b0;
      dir_q        <= 1'b0;
      fault_q      <= 1'b0;
      meas_valid_q <= 1'b0;
      stalled_q    <= 1'b0;
    end else begin
      s_q          <= signals;
      drv_prev_q   <= drive;
      state_q      <= state_d;
      pwm_q        <= pwm_d;
      dir_q        <= dir_d;
      fault_q      <= fault_d;
      meas_valid_q <= meas_valid_d;
      stalled_q    <= stalled_d;
    end
  end

  pwm_period_counter #(
    .CNT_W      (CNT_W),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_counter (
    .clk_i     (Clock),
    .rst_ni    (nReset),
    .clear_i   (cnt_clear),
    .load_i    (cnt_load),
    .capture_i (cnt_capture),
    .timeout_i (cnt_timeout),
    .count_i   (cnt_count),
    .drive_i   (drive),
    .at_limit_o(at_limit),
    .duty_o    (duty),
    .period_o  (period)
  );

  assign pwm_out       = pwm_q;
  assign direction_out = dir_q;
  assign fault         = fault_q;
  assign meas_valid    = meas_valid_q;
  assign stalled       = stalled_q;

endmodule

// File: tb/tb_bridge_key_monitor.sv
// Directed bench: expected strobes are queued as stimulus is driven and matched on meas_valid.
module tb_bridge_key_monitor;

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned TIMEOUT = 20;

  logic             Clock;
  logic             nReset;
  logic [3:0]       signals;
  logic             fault_clear;
  logic             pwm_out;
  logic             direction_out;
  logic [CNT_W-1:0] duty;
  logic [CNT_W-1:0] period;
  logic             meas_valid;
  logic             stalled;
  logic             fault;

  typedef struct {
    int         cyc;
    logic [15:0] duty;
    logic [15:0] period;
    logic        stalled;
  } exp_t;

  exp_t exp_q[$];
  int   cyc;
  int   tests;
  int   fails;

  bridge_key_monitor #(
    .CNT_W      (CNT_W),
    .TIMEOUT_CYC(TIMEOUT)
  ) dut (
    .Clock        (Clock),
    .nReset       (nReset),
    .signals      (signals),
    .fault_clear  (fault_clear),
    .pwm_out      (pwm_out),
    .direction_out(direction_out),
    .duty         (duty),
    .period       (period),
    .meas_valid   (meas_valid),
    .stalled      (stalled),
    .fault        (fault)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
    end
  endtask

  // Hold pattern p on the key bus for n clocks; returns 1 time unit after the last edge.
  task automatic drive(input logic [3:0] p, input int n);
    for (int i = 0; i < n; i++) begin
      signals = p;
      @(posedge Clock);
      #1;
    end
  endtask

  // Call just before driving the rising pattern; the strobe lands lat clocks later.
  task automatic expect_meas(input int d, input int p, input logic st, input int lat);
    exp_t e;
    e.cyc     = cyc + lat;
    e.duty    = 16'(d);
    e.period  = 16'(p);
    e.stalled = st;
    exp_q.push_back(e);
  endtask

  always @(negedge Clock) begin
    if (nReset && meas_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("strobe_cycle", 32'(cyc), 32'(e.cyc));
        check("strobe_duty", 32'(duty), 32'(e.duty));
        check("strobe_period", 32'(period), 32'(e.period));
        check("strobe_stalled", 32'(stalled), 32'(e.stalled));
      end
    end
  end

  initial begin
    cyc         = 0;
    tests       = 0;
    fails       = 0;
    nReset      = 1'b0;
    signals     = 4'b1001;
    fault_clear = 1'b0;

    // Reset held with a drive pattern present.
    repeat (2) @(posedge Clock);
    #1;
    check("rst_pwm", 32'(pwm_out), 32'd0);
    check("rst_dir", 32'(direction_out), 32'd0);
    check("rst_duty", 32'(duty), 32'd0);
    check("rst_period", 32'(period), 32'd0);
    check("rst_valid", 32'(meas_valid), 32'd0);
    check("rst_stalled", 32'(stalled), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    nReset = 1'b1;

    drive(4'b1001, 1);
    check("pwm_lat1", 32'(pwm_out), 32'd0);
    drive(4'b1001, 1);
    check("pwm_lat2", 32'(pwm_out), 32'd1);
    check("dir_fwd", 32'(direction_out), 32'd0);
    drive(4'b1001, 1);
    drive(4'b0101, 5);

    // Forward 3/8.
    for (int i = 0; i < 3; i++) begin
      expect_meas(3, 8, 1'b0, 2);
      drive(4'b1001, 3);
      drive(4'b0101, 5);
    end

    // Reverse 6/8.
    expect_meas(3, 8, 1'b0, 2);
    drive(4'b0110, 2);
    check("dir_rev", 32'(direction_out), 32'd1);
    check("pwm_rev", 32'(pwm_out), 32'd1);
    drive(4'b0110, 4);
    drive(4'b0000, 2);
    check("dir_hold_off", 32'(direction_out), 32'd1);
    check("pwm_off", 32'(pwm_out), 32'd0);
    for (int i = 0; i < 2; i++) begin
      expect_meas(6, 8, 1'b0, 2);
      drive(4'b0110, 6);
      drive(4'b0000, 2);
    end
    check("hold_duty", 32'(duty), 32'd6);
    check("hold_period", 32'(period), 32'd8);

    // Constant drive until timeout.
    expect_meas(6, 8, 1'b0, 2);
    expect_meas(TIMEOUT, TIMEOUT, 1'b1, 2 + TIMEOUT);
    drive(4'b1001, 30);
    check("stall_set", 32'(stalled), 32'd1);
    check("stall_duty", 32'(duty), 32'(TIMEOUT));
    check("stall_period", 32'(period), 32'(TIMEOUT));
    drive(4'b0000, 2);
    drive(4'b1001, 3);
    drive(4'b0101, 5);
    check("stall_held", 32'(stalled), 32'd1);
    expect_meas(3, 8, 1'b0, 2);
    drive(4'b1001, 3);
    check("stall_clear", 32'(stalled), 32'd0);
    drive(4'b0000, 2);

    // Single-cycle shoot-through mid-period.
    expect_meas(3, 5, 1'b0, 2);
    drive(4'b1001, 3);
    drive(4'b1100, 1);
    check("fault_lat1", 32'(fault), 32'd0);
    check("pwm_pre_fault", 32'(pwm_out), 32'd1);
    drive(4'b0000, 1);
    check("fault_set", 32'(fault), 32'd1);
    check("fault_pwm", 32'(pwm_out), 32'd0);
    drive(4'b0011, 1);
    fault_clear = 1'b1;
    drive(4'b0011, 3);
    check("fault_clr_ignored", 32'(fault), 32'd1);
    fault_clear = 1'b0;
    drive(4'b0000, 1);
    check("fault_still", 32'(fault), 32'd1);
    fault_clear = 1'b1;
    drive(4'b0000, 1);
    check("fault_cleared", 32'(fault), 32'd0);
    fault_clear = 1'b0;

    // Back in idle: first rise is silent, then minimum 2-cycle periods.
    drive(4'b1001, 3);
    drive(4'b0101, 5);
    expect_meas(3, 8, 1'b0, 2);
    drive(4'b1001, 1);
    drive(4'b0000, 1);
    expect_meas(1, 2, 1'b0, 2);
    drive(4'b1001, 1);
    drive(4'b0000, 1);
    expect_meas(1, 2, 1'b0, 2);
    drive(4'b1001, 5);

    // Reset mid-period.
    nReset = 1'b0;
    #1;
    check("midrst_pwm", 32'(pwm_out), 32'd0);
    check("midrst_duty", 32'(duty), 32'd0);
    check("midrst_period", 32'(period), 32'd0);
    check("midrst_valid", 32'(meas_valid), 32'd0);
    check("midrst_queue", 32'(exp_q.size()), 32'd0);
    signals = 4'b0000;
    repeat (2) @(posedge Clock);
    #1;
    nReset = 1'b1;
    drive(4'b0000, 2);
    drive(4'b1001, 4);
    drive(4'b0000, 3);
    expect_meas(4, 7, 1'b0, 2);
    drive(4'b1001, 1);
    drive(4'b0000, 2);
    check("post_rst_duty", 32'(duty), 32'd4);
    check("post_rst_period", 32'(period), 32'd7);

    drive(4'b0000, 4);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
